md_unit: RTL and testbench



---
 rtl/md_unit.sv | 182 ++++++++++++++++++
 tb/tb_md_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
//
// Executes mult/multu/div/divu. It also accepts mthi/mtlo writes and can be
// aborted by a flush. HI/LO only change at the completion edge of an
// operation, or on an mthi/mtlo write while the unit is idle.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active low
//   start     in   launch the operation selected by op using d1/d2
//   op        in   00 mult, 01 multu, 10 div, 11 divu
//   d1, d2    in   rs / rt operands (d1 is also the mthi/mtlo data)
//   we        in   mthi/mtlo write strobe, honoured only when idle
//   hilo_sel  in   target of we: 1 = HI, 0 = LO
//   flush     in   abort the in-flight operation, or suppress a start
//   busy      out  an operation is in flight
//   done      out  one-cycle completion pulse (new HI/LO already visible)
//   dz        out  divide by zero, valid together with done
//   hi, lo    out  HI / LO registers
//
// state  | meaning
// S_IDLE | waiting for start or an mthi/mtlo write
// S_MUL  | multiply in flight, counter runs MUL_CYCLES-1 down to 0
// S_DIV  | WIDTH restoring steps (cnt WIDTH..1), then the sign fix-up at cnt 0
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic             we,
  input  logic             hilo_sel,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES - 1) ? WIDTH : MUL_CYCLES - 1;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;          // raw operands, kept for signs and dz
  logic             signed_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dz_q;

  logic [2*WIDTH-1:0] a_ext, b_ext, prod_d;
  logic [WIDTH:0]     shift_d, trial_d;
  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [WIDTH-1:0]   mag_a_d, mag_b_d;

  // The low 2*WIDTH bits of the product of the extended operands are the
  // exact product, signed or unsigned.
  always_comb begin
    a_ext  = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext  = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_d = a_ext * b_ext;
  end

  // Operand magnitudes at load. The most-negative value maps to itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    mag_a_d = (!op[0] && d1[WIDTH-1]) ? -d1 : d1;
    mag_b_d = (!op[0] && d2[WIDTH-1]) ? -d2 : d2;
  end

  // One restoring step. The dividend bits shift out of quo_q as quotient
  // bits shift in. Bit WIDTH of the trial difference is its sign.
  always_comb begin
    shift_d = {rem_q, quo_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, dvs_q};
    if (!trial_d[WIDTH]) begin
      rem_d = trial_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shift_d[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            a_q      <= d1;
            b_q      <= d2;
            signed_q <= ~op[0];
            busy_q   <= 1'b1;
            if (op[1]) begin
              state_q <= S_DIV;
              cnt_q   <= CW'(WIDTH);
              rem_q   <= '0;
              quo_q   <= mag_a_d;
              dvs_q   <= mag_b_d;
            end else begin
              state_q <= S_MUL;
              cnt_q   <= CW'(MUL_CYCLES - 1);
            end
          end else if (we && !start) begin
            if (hilo_sel) hi_q <= d1;
            else          lo_q <= d1;
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            hi_q    <= prod_d[2*WIDTH-1:WIDTH];
            lo_q    <= prod_d[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            if (b_q == '0) begin
              lo_q <= '1;
              hi_q <= a_q;
              dz_q <= 1'b1;
            end else begin
              lo_q <= (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
              hi_q <= (signed_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
            end
            done_q  <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit (WIDTH=32, MUL_CYCLES=5) plus a randomised
// run of a WIDTH=16, MUL_CYCLES=1 instance against a behavioural model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_md_unit;

  logic        clk, rst;
  logic        start, we, hilo_sel, flush;
  logic [1:0]  op;
  logic [31:0] d1, d2;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        s_start, s_we, s_hilo_sel, s_flush;
  logic [1:0]  s_op;
  logic [15:0] s_d1, s_d2;
  logic        s_busy, s_done, s_dz;
  logic [15:0] s_hi, s_lo;

  int checks   = 0;
  int failures = 0;

  md_unit #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .d1(d1), .d2(d2),
    .we(we), .hilo_sel(hilo_sel), .flush(flush),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(16), .MUL_CYCLES(1)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .op(s_op), .d1(s_d1), .d2(s_d2),
    .we(s_we), .hilo_sel(s_hilo_sel), .flush(s_flush),
    .busy(s_busy), .done(s_done), .dz(s_dz), .hi(s_hi), .lo(s_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait for done. Returns the number of sampled
  // cycles with busy high and the outputs seen in the done cycle; ends on
  // the falling edge of the done cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nbusy, output logic [31:0] rhi, output logic [31:0] rlo,
                       output logic rdz, output bit timeout);
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; timeout = 1'b1; rhi = 'x; rlo = 'x; rdz = 1'bx;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        timeout = 1'b0; rhi = hi; rlo = lo; rdz = dz;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 0; we = 0; hilo_sel = 0; flush = 0; op = 0; d1 = 0; d2 = 0;
    s_start = 0; s_we = 0; s_hilo_sel = 0; s_flush = 0; s_op = 0; s_d1 = 0; s_d2 = 0;
    repeat (2) @(negedge clk);
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", dz); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int nb; logic [31:0] rh, rl; logic rz; bit to;
    do_op(2'b00, 32'hFFFF_FFFF, 32'h2, nb, rh, rl, rz, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL mult_timeout got=%b exp=0", to); end
    checks++; if (nb !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", nb); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", rh); end
    checks++; if (rl !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", rl); end
    checks++; if (rz !== 1'b0) begin failures++; $display("FAIL mult_dz got=%b exp=0", rz); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    do_op(2'b01, 32'hFFFF_FFFF, 32'h2, nb, rh, rl, rz, to);
    checks++; if (rh !== 32'h1) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", rh); end
    checks++; if (rl !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", rl); end
    checks++; if (nb !== 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", nb); end
  endtask

  task automatic test_div;
    int nb; logic [31:0] rh, rl; logic rz; bit to;
    do_op(2'b10, 32'hFFFF_FFF9, 32'h2, nb, rh, rl, rz, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL div_timeout got=%b exp=0", to); end
    checks++; if (nb !== 33) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=33", nb); end
    checks++; if (rl !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", rl); end
    checks++; if (rh !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", rh); end
    do_op(2'b11, 32'd100, 32'd7, nb, rh, rl, rz, to);
    checks++; if (rl !== 32'd14) begin failures++; $display("FAIL divu_lo got=%0d exp=14", rl); end
    checks++; if (rh !== 32'd2) begin failures++; $display("FAIL divu_hi got=%0d exp=2", rh); end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, nb, rh, rl, rz, to);
    checks++; if (rl !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", rl); end
    checks++; if (rh !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", rh); end
    checks++; if (rz !== 1'b0) begin failures++; $display("FAIL div_ovf_dz got=%b exp=0", rz); end
    do_op(2'b10, 32'd17, 32'hFFFF_FFFB, nb, rh, rl, rz, to);
    checks++; if (rl !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_divisor_lo got=%h exp=fffffffd", rl); end
    checks++; if (rh !== 32'd2) begin failures++; $display("FAIL div_neg_divisor_hi got=%h exp=2", rh); end
  endtask

  task automatic test_div_zero;
    int nb; logic [31:0] rh, rl; logic rz; bit to;
    do_op(2'b11, 32'h1234, 32'h0, nb, rh, rl, rz, to);
    checks++; if (rl !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_dz_lo got=%h exp=ffffffff", rl); end
    checks++; if (rh !== 32'h1234) begin failures++; $display("FAIL divu_dz_hi got=%h exp=00001234", rh); end
    checks++; if (rz !== 1'b1) begin failures++; $display("FAIL divu_dz_flag got=%b exp=1", rz); end
    @(negedge clk);
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL dz_after_done got=%b exp=0", dz); end
    do_op(2'b10, 32'hFFFF_FFFB, 32'h0, nb, rh, rl, rz, to);
    checks++; if (rh !== 32'hFFFF_FFFB) begin failures++; $display("FAIL div_dz_hi got=%h exp=fffffffb", rh); end
    checks++; if (rl !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_dz_lo got=%h exp=ffffffff", rl); end
    checks++; if (rz !== 1'b1) begin failures++; $display("FAIL div_dz_flag got=%b exp=1", rz); end
  endtask

  task automatic test_flush;
    bit seen;
    @(negedge clk); we = 1; hilo_sel = 1; d1 = 32'hA5A5_A5A5;
    @(negedge clk); we = 1; hilo_sel = 0; d1 = 32'd5;
    @(negedge clk); we = 0;
    checks++; if (hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL mthi got=%h exp=a5a5a5a5", hi); end
    checks++; if (lo !== 32'd5) begin failures++; $display("FAIL mtlo got=%h exp=5", lo); end
    start = 1; op = 2'b10; d1 = 32'd100; d2 = 32'd3;
    @(negedge clk); start = 0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b exp=1", busy); end
    checks++; if (lo !== 32'd5) begin failures++; $display("FAIL lo_held_midop got=%h exp=5", lo); end
    flush = 1;
    @(negedge clk); flush = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy_after got=%b exp=0", busy); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_no_done got=%b exp=0", seen); end
    checks++; if (lo !== 32'd5) begin failures++; $display("FAIL flush_lo got=%h exp=5", lo); end
    checks++; if (hi !== 32'hA5A5_A5A5) begin failures++; $display("FAIL flush_hi got=%h exp=a5a5a5a5", hi); end
    start = 1; flush = 1; op = 2'b01; d1 = 32'd3; d2 = 32'd3;
    @(negedge clk); start = 0; flush = 0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_flush_busy got=%b exp=0", busy); end
    seen = 0;
    repeat (8) begin @(negedge clk); if (done || busy) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL start_flush_no_op got=%b exp=0", seen); end
    checks++; if (lo !== 32'd5) begin failures++; $display("FAIL start_flush_lo got=%h exp=5", lo); end
  endtask

  task automatic test_ignored;
    int n; bit seen;
    @(negedge clk); start = 1; op = 2'b00; d1 = 32'd3; d2 = 32'd4;
    @(negedge clk);
    start = 1; op = 2'b11; d1 = 32'h0000_DEAD; d2 = 32'd1; we = 1; hilo_sel = 1;
    n = 1;
    @(negedge clk); start = 0; we = 0; n = 2;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 6) begin failures++; $display("FAIL ignored_latency got=%0d exp=6", n); end
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL ignored_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd12) begin failures++; $display("FAIL ignored_lo got=%h exp=12", lo); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL ignored_second_start got=%b exp=0", seen); end
    start = 1; op = 2'b01; d1 = 32'd7; d2 = 32'd6; we = 1; hilo_sel = 1;
    @(negedge clk); start = 0; we = 0;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL start_we_hi got=%h exp=0", hi); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_we_busy got=%b exp=1", busy); end
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      @(negedge clk);
    end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL start_we_lo got=%0d exp=42", lo); end
  endtask

  task automatic test_back_to_back;
    int nb, n; logic [31:0] rh, rl; logic rz; bit to;
    do_op(2'b01, 32'd6, 32'd7, nb, rh, rl, rz, to);
    checks++; if (rl !== 32'd42) begin failures++; $display("FAIL b2b_first_lo got=%0d exp=42", rl); end
    start = 1; op = 2'b01; d1 = 32'd3; d2 = 32'd5;
    @(negedge clk); start = 0; n = 1;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 6) begin failures++; $display("FAIL b2b_latency got=%0d exp=6", n); end
    checks++; if (lo !== 32'd15) begin failures++; $display("FAIL b2b_second_lo got=%0d exp=15", lo); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL b2b_second_hi got=%0d exp=0", hi); end
  endtask

  task automatic test_async_reset;
    int nb; logic [31:0] rh, rl; logic rz; bit to;
    @(negedge clk); we = 1; hilo_sel = 1; d1 = 32'h1111;
    @(negedge clk); we = 0; start = 1; op = 2'b00; d1 = 32'd9; d2 = 32'd9;
    @(negedge clk); start = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL areset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL areset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL areset_done got=%b exp=0", done); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_idle got=%b exp=0", busy); end
    do_op(2'b01, 32'd2, 32'd3, nb, rh, rl, rz, to);
    checks++; if (rl !== 32'd6) begin failures++; $display("FAIL areset_restart_lo got=%0d exp=6", rl); end
    checks++; if (nb !== 5) begin failures++; $display("FAIL areset_restart_busy got=%0d exp=5", nb); end
  endtask

  function automatic logic [32:0] ref16(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, q, r;
    int unsigned ua, ub, uq, ur;
    logic [31:0] p;
    logic [15:0] h, l;
    logic z;
    sa = int'($signed(a)); sb = int'($signed(b));
    ua = {16'h0, a}; ub = {16'h0, b};
    z = 1'b0; h = '0; l = '0;
    case (o)
      2'b00: begin p = sa * sb; h = p[31:16]; l = p[15:0]; end
      2'b01: begin p = ua * ub; h = p[31:16]; l = p[15:0]; end
      2'b10: begin
        if (b == 16'h0) begin h = a; l = 16'hFFFF; z = 1'b1; end
        else begin q = sa / sb; r = sa % sb; h = r[15:0]; l = q[15:0]; end
      end
      default: begin
        if (b == 16'h0) begin h = a; l = 16'hFFFF; z = 1'b1; end
        else begin uq = ua / ub; ur = ua % ub; h = ur[15:0]; l = uq[15:0]; end
      end
    endcase
    return {z, h, l};
  endfunction

  task automatic test_random16;
    logic [1:0]  o;
    logic [15:0] a, b;
    logic [32:0] exp_v, got_v;
    int n, exp_n;
    for (int k = 0; k < 1000; k++) begin
      o = 2'($urandom_range(0, 3));
      a = 16'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 19) == 0) begin a = 16'h8000; b = 16'hFFFF; end
      exp_v = ref16(o, a, b);
      exp_n = o[1] ? 18 : 2;
      @(negedge clk); s_start = 1; s_op = o; s_d1 = a; s_d2 = b;
      @(negedge clk); s_start = 0; n = 1;
      for (int i = 0; i < 40; i++) begin
        if (s_done) break;
        n++;
        @(negedge clk);
      end
      got_v = {s_dz, s_hi, s_lo};
      checks++;
      if (got_v !== exp_v || n !== exp_n) begin
        failures++;
        $display("FAIL rand16 op=%0d a=%h b=%h got dz/hi/lo=%h cyc=%0d exp=%h cyc=%0d",
                 o, a, b, got_v, n, exp_v, exp_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_flush();
    test_ignored();
    test_back_to_back();
    test_async_reset();
    test_random16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
